// File: rtl/blink_scheduler.sv
// LED blink sequencer: a prescaled tick drives a programmed number of
// on/off cycles, either with all LEDs together or as a walking one-hot.
module blink_scheduler #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int N_LEDS  = 4,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [PER_W-1:0]  period_i,
    input  logic [CNT_W-1:0]  blinks_i,
    input  logic              walk_i,
    output logic [N_LEDS-1:0] led_po,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

    state_t state, state_next;

    logic [PRE_W-1:0]  pre;
    logic [PER_W-1:0]  period_q;
    logic [PER_W-1:0]  half;
    logic [CNT_W-1:0]  blinks_q;
    logic [CNT_W-1:0]  completed;
    logic [IDX_W-1:0]  idx;
    logic              walk_q;

    logic              tick;
    logic              running;
    logic              accept;
    logic              half_end;
    logic              last_blink;
    logic              advance;
    logic [IDX_W-1:0]  idx_inc;

    logic [N_LEDS-1:0] led_next;
    logic              busy_next;
    logic              done_next;
    logic [IDX_W-1:0]  idx_sel;
    logic              walk_sel;

    assign tick       = (pre == PRE_W'(DIV - 1));
    assign running    = (state == ON) || (state == OFF);
    assign accept     = (state == IDLE) && start_i && !stop_i &&
                        (period_i != '0) && (blinks_i != '0);
    assign half_end   = tick && (half == period_q - PER_W'(1));
    assign last_blink = (completed == blinks_q - CNT_W'(1));
    assign advance    = (state == OFF) && !stop_i && half_end && !last_blink;
    assign idx_inc    = (idx == IDX_W'(N_LEDS - 1)) ? '0 : idx + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ON;
                end
            end
            ON: begin
                if (stop_i) begin
                    state_next = IDLE;
                end else if (half_end) begin
                    state_next = OFF;
                end
            end
            OFF: begin
                if (stop_i) begin
                    state_next = IDLE;
                end else if (half_end) begin
                    state_next = last_blink ? DONE : ON;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output values are computed from the next state so the registered
    // outputs line up exactly with the state they describe.
    always_comb begin
        idx_sel   = idx;
        walk_sel  = walk_q;
        led_next  = '0;
        busy_next = 1'b0;
        done_next = 1'b0;
        if (accept) begin
            idx_sel  = '0;
            walk_sel = walk_i;
        end else if (advance) begin
            idx_sel = idx_inc;
        end
        case (state_next)
            ON: begin
                busy_next = 1'b1;
                led_next  = walk_sel ? (N_LEDS'(1) << idx_sel) : '1;
            end
            OFF: begin
                busy_next = 1'b1;
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
                led_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            led_po <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            led_po <= led_next;
            busy_o <= busy_next;
            done_o <= done_next;
        end
    end

    // Prescaler only runs inside a sequence, so the first tick lands
    // exactly DIV cycles after entering ON.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre <= '0;
        end else if (running && !stop_i) begin
            pre <= tick ? '0 : pre + PRE_W'(1);
        end else begin
            pre <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            half <= '0;
        end else if (!running || stop_i || half_end) begin
            half <= '0;
        end else if (tick) begin
            half <= half + PER_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_q  <= '0;
            blinks_q  <= '0;
            walk_q    <= 1'b0;
            completed <= '0;
            idx       <= '0;
        end else if (accept) begin
            period_q  <= period_i;
            blinks_q  <= blinks_i;
            walk_q    <= walk_i;
            completed <= '0;
            idx       <= '0;
        end else if (advance) begin
            completed <= completed + CNT_W'(1);
            idx       <= idx_inc;
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Scoreboard bench for blink_scheduler: expected LED pulses and done
// latencies are queued at stimulus time and checked by a monitor.
module tb_blink_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic [7:0]  blinks;
    logic        walk;
    logic [3:0]  led;
    logic        busy;
    logic        done;

    typedef struct {
        logic [3:0] pattern;
        int         length;
    } pulse_t;

    pulse_t pulse_q[$];
    int     done_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b1;

    blink_scheduler #(
        .CLK_HZ (100),
        .TICK_HZ(10),
        .N_LEDS (4),
        .PER_W  (16),
        .CNT_W  (8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .stop_i  (stop),
        .period_i(period),
        .blinks_i(blinks),
        .walk_i  (walk),
        .led_po  (led),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int p, input int b, input bit w, input bit s, input bit k);
        period = 16'(p);
        blinks = 8'(b);
        walk   = w;
        start  = s;
        stop   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pushExpect(input int p, input int n, input bit w, input bit with_done, input int b);
        pulse_t e;
        for (int i = 0; i < n; i++) begin
            e.pattern = w ? 4'(1 << (i % 4)) : 4'hF;
            e.length  = p * 10;
            pulse_q.push_back(e);
        end
        if (with_done) done_q.push_back(2 * b * p * 10);
    endtask

    task automatic runSeq(input int p, input int b, input bit w);
        pushExpect(p, b, w, 1'b1, b);
        applyStimulus(p, b, w, 1'b1, 1'b0);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while ((busy || done) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s timeout: still busy after %0d cycles, expected idle", name, n);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, "_pulses_left"}, pulse_q.size(), 0);
        checkOutput({name, "_dones_left"}, done_q.size(), 0);
        pulse_q.delete();
        done_q.delete();
    endtask

    // Monitor: measures each steady LED pulse and each done latency.
    bit         in_pulse  = 1'b0;
    logic [3:0] cur_led   = '0;
    int         cur_len   = 0;
    bit         busy_prev = 1'b0;
    int         busy_rise = 0;

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            in_pulse = 1'b0;
        end else begin
            if (busy && !busy_prev) busy_rise = cyc;
            if (in_pulse && led !== cur_led) begin
                in_pulse = 1'b0;
                if (pulse_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_pulse: got pattern %b len %0d, expected none", cur_led, cur_len);
                end else begin
                    pulse_t e;
                    e = pulse_q.pop_front();
                    checkOutput("pulse_pattern", int'(cur_led), int'(e.pattern));
                    checkOutput("pulse_length", cur_len, e.length);
                end
            end
            if (!in_pulse && led !== 4'h0) begin
                in_pulse = 1'b1;
                cur_led  = led;
                cur_len  = 0;
            end
            if (in_pulse) cur_len++;
            if (done) begin
                checkOutput("busy_low_at_done", int'(busy), 0);
                if (done_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_done: got done after %0d cycles, expected none", cyc - busy_rise);
                end else begin
                    checkOutput("done_latency", cyc - busy_rise, done_q.pop_front());
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = '0;
        blinks = '0;
        walk   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_led", int'(led), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        runSeq(2, 3, 1'b0);
        checkOutput("basic_busy_rise", int'(busy), 1);
        checkOutput("basic_first_led", int'(led), 15);
        waitIdle("basic", 200);

        runSeq(1, 6, 1'b1);
        checkOutput("walk_first_led", int'(led), 1);
        waitIdle("walk", 200);

        pushExpect(1, 2, 1'b0, 1'b0, 3);
        applyStimulus(1, 3, 1'b0, 1'b1, 1'b0);
        repeat (34) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_led", int'(led), 0);
        waitIdle("abort", 50);
        runSeq(1, 3, 1'b0);
        waitIdle("after_abort", 100);

        applyStimulus(0, 3, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("period0_busy", int'(busy), 0);
        applyStimulus(2, 0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("blinks0_busy", int'(busy), 0);
        applyStimulus(2, 3, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("start_stop_busy", int'(busy), 0);
        checkOutput("start_stop_done", int'(done), 0);
        waitIdle("ignored", 20);

        runSeq(2, 2, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        applyStimulus(5, 1, 1'b1, 1'b1, 1'b0);
        waitIdle("restart_busy", 150);

        mon_en = 1'b0;
        applyStimulus(2, 3, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_led", int'(led), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_done", int'(done), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_rst_busy", int'(busy), 0);
        checkOutput("post_rst_led", int'(led), 0);
        mon_en = 1'b1;

        runSeq(1, 255, 1'b0);
        waitIdle("limit", 6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
